// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer: fetches operands from an 8x16 register file, shifts operand B,
// drives an external 2-bit-op ALU, latches CMP flags and writes results back.
module alu_sequencer #(
  parameter int unsigned DATA_W   = 16,
  parameter bit          CLR_REGS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       instr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] alu_ain,
  output logic [DATA_W-1:0] alu_bin,
  output logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [2:0]        alu_z,
  output logic [2:0]        status,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_RD_A, S_RD_B, S_EXEC, S_WB, S_WB_IMM
  } state_t;

  state_t state_q, state_d;

  logic [15:0]       instr_q;
  logic [DATA_W-1:0] a_q, b_q, c_q;
  logic [2:0]        status_q;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rf_q [8];

  logic              rf_we;
  logic [2:0]        rf_wa;
  logic [DATA_W-1:0] rf_wd;

  logic [2:0]        opc;
  logic [1:0]        op, sh;
  logic [2:0]        rn, rd, rm;
  logic [DATA_W-1:0] imm_sext;
  logic              is_dp, is_cmp, is_movi, is_movr, needs_a, legal;

  assign opc      = instr_q[15:13];
  assign op       = instr_q[12:11];
  assign rn       = instr_q[10:8];
  assign rd       = instr_q[7:5];
  assign sh       = instr_q[4:3];
  assign rm       = instr_q[2:0];
  assign imm_sext = {{(DATA_W-8){instr_q[7]}}, instr_q[7:0]};

  assign is_dp   = (opc == 3'b101);
  assign is_cmp  = is_dp && (op == 2'b01);
  assign is_movi = (opc == 3'b110) && (op == 2'b10);
  assign is_movr = (opc == 3'b110) && (op == 2'b00);
  // MVN only needs the B operand, so it skips RD_A like MOV reg.
  assign needs_a = is_dp && (op != 2'b11);
  assign legal   = is_dp || is_movi || is_movr;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_DECODE;
      S_DECODE: begin
        if (!legal)       state_d = S_IDLE;
        else if (is_movi) state_d = S_WB_IMM;
        else if (needs_a) state_d = S_RD_A;
        else              state_d = S_RD_B;
      end
      S_RD_A:   state_d = S_RD_B;
      S_RD_B:   state_d = S_EXEC;
      S_EXEC:   state_d = is_cmp ? S_IDLE : S_WB;
      S_WB:     state_d = S_IDLE;
      S_WB_IMM: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    alu_ain = is_movr ? '0 : a_q;
    alu_op  = is_movr ? 2'b00 : op;
    case (sh)
      2'b01:   alu_bin = {b_q[DATA_W-2:0], 1'b0};
      2'b10:   alu_bin = {1'b0, b_q[DATA_W-1:1]};
      2'b11:   alu_bin = {b_q[DATA_W-1], b_q[DATA_W-1:1]};
      default: alu_bin = b_q;
    endcase
    rf_we  = (state_q == S_WB) || (state_q == S_WB_IMM);
    rf_wa  = (state_q == S_WB_IMM) ? rn : rd;
    rf_wd  = (state_q == S_WB_IMM) ? imm_sext : c_q;
    err_d  = (state_q == S_DECODE) && !legal;
    done_d = err_d || rf_we || ((state_q == S_EXEC) && is_cmp);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= done_d;
      err_q  <= err_d;
      if (state_q == S_IDLE && start) instr_q <= instr;
      if (state_q == S_RD_A) a_q <= rf_q[rn];
      if (state_q == S_RD_B) b_q <= rf_q[rm];
      if (state_q == S_EXEC) begin
        c_q <= alu_out;
        if (is_cmp) status_q <= alu_z;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if (CLR_REGS) begin
        for (int unsigned i = 0; i < 8; i++) rf_q[i[2:0]] <= '0;
      end
    end else if (rf_we) begin
      rf_q[rf_wa] <= rf_wd;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign status   = status_q;
  assign dbg_data = rf_q[dbg_sel];

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a behavioural ALU closes the loop, a vector table
// covers the instruction set, and hand sequences cover busy-start and mid-instruction reset.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] instr;
  logic        busy, done, err;
  logic [15:0] alu_ain, alu_bin, alu_out;
  logic [1:0]  alu_op;
  logic [2:0]  alu_z, status, dbg_sel;
  logic [15:0] dbg_data;

  int unsigned checks = 0;
  int unsigned errors = 0;

  alu_sequencer #(.DATA_W(16), .CLR_REGS(1'b1)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .instr    (instr),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .alu_ain  (alu_ain),
    .alu_bin  (alu_bin),
    .alu_op   (alu_op),
    .alu_out  (alu_out),
    .alu_z    (alu_z),
    .status   (status),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  // Reference ALU: ADD/SUB/AND/NOT-B with {V,N,Z}
  logic        ovf;
  always_comb begin
    alu_out = '0;
    ovf     = 1'b0;
    case (alu_op)
      2'b00: begin
        alu_out = alu_ain + alu_bin;
        ovf = (alu_ain[15] == alu_bin[15]) && (alu_out[15] != alu_ain[15]);
      end
      2'b01: begin
        alu_out = alu_ain - alu_bin;
        ovf = (alu_ain[15] != alu_bin[15]) && (alu_out[15] != alu_ain[15]);
      end
      2'b10:   alu_out = alu_ain & alu_bin;
      default: alu_out = ~alu_bin;
    endcase
    alu_z = {ovf, alu_out[15], (alu_out == 16'h0000)};
  end

  typedef struct {
    logic [15:0] ins;
    int unsigned lat;
    logic        err;
    logic [2:0]  sel;
    logic [15:0] data;
    logic [2:0]  st;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic rd_chk(input string nm, input logic [2:0] sel, input logic [15:0] exp);
    dbg_sel = sel;
    #1;
    chk(nm, {16'h0, dbg_data}, {16'h0, exp});
  endtask

  // Drive one instruction and count edges (acceptance edge = 1) until done.
  task automatic run_instr(input string nm, input logic [15:0] ins,
                           input int unsigned exp_lat, input logic exp_err);
    int unsigned n;
    bit seen;
    instr = ins;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    instr = ~ins;
    n = 1;
    seen = 1'b0;
    while (!seen && n <= 12) begin
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no done within 12 edges", nm);
    end else begin
      chk({nm, "_latency"}, n, exp_lat);
      chk({nm, "_err"}, {31'h0, err}, {31'h0, exp_err});
      chk({nm, "_busy"}, {31'h0, busy}, 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{16'hD007, 3, 1'b0, 3'd0, 16'h0007, 3'b000}; // MOV R0,#7
    vecs[1]  = '{16'hD1FF, 3, 1'b0, 3'd1, 16'hFFFF, 3'b000}; // MOV R1,#-1
    vecs[2]  = '{16'hA148, 6, 1'b0, 3'd2, 16'h000D, 3'b000}; // ADD R2,R1,R0 LSL1
    vecs[3]  = '{16'hA800, 5, 1'b0, 3'd0, 16'h0007, 3'b001}; // CMP R0,R0
    vecs[4]  = '{16'hB878, 5, 1'b0, 3'd3, 16'hFFFC, 3'b001}; // MVN R3,R0 ASR1
    vecs[5]  = '{16'hAB00, 5, 1'b0, 3'd3, 16'hFFFC, 3'b010}; // CMP R3,R0
    vecs[6]  = '{16'hB391, 6, 1'b0, 3'd4, 16'h7FFC, 3'b010}; // AND R4,R3,R1 LSR1
    vecs[7]  = '{16'hC0A9, 5, 1'b0, 3'd5, 16'hFFFE, 3'b010}; // MOV R5,R1 LSL1
    vecs[8]  = '{16'hA121, 6, 1'b0, 3'd1, 16'hFFFE, 3'b010}; // ADD R1,R1,R1
    vecs[9]  = '{16'hD680, 3, 1'b0, 3'd6, 16'hFF80, 3'b010}; // MOV R6,#-128
    vecs[10] = '{16'hAC06, 5, 1'b0, 3'd4, 16'h7FFC, 3'b110}; // CMP R4,R6 (overflow)
    vecs[11] = '{16'h0000, 2, 1'b1, 3'd0, 16'h0007, 3'b110}; // illegal opc 000
    vecs[12] = '{16'hD800, 2, 1'b1, 3'd6, 16'hFF80, 3'b110}; // illegal 110/11
    vecs[13] = '{16'hE000, 2, 1'b1, 3'd2, 16'h000D, 3'b110}; // illegal opc 111
    vecs[14] = '{16'hC0F6, 5, 1'b0, 3'd7, 16'h7FC0, 3'b110}; // MOV R7,R6 LSR1
    vecs[15] = '{16'hC0FE, 5, 1'b0, 3'd7, 16'hFFC0, 3'b110}; // MOV R7,R6 ASR1

    reset   = 1'b1;
    start   = 1'b0;
    instr   = '0;
    dbg_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",   {31'h0, busy}, 32'h0);
    chk("reset_done",   {31'h0, done}, 32'h0);
    chk("reset_err",    {31'h0, err},  32'h0);
    chk("reset_status", {29'h0, status}, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) rd_chk("reset_reg", 3'(i), 16'h0000);
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      run_instr($sformatf("vec%0d", i), vecs[i].ins, vecs[i].lat, vecs[i].err);
      chk($sformatf("vec%0d_status", i), {29'h0, status}, {29'h0, vecs[i].st});
      rd_chk($sformatf("vec%0d_reg", i), vecs[i].sel, vecs[i].data);
    end

    // start held during DECODE must be ignored: R7 gets #5, not #0xAA
    @(posedge clk); #1;
    instr = 16'hD705;
    start = 1'b1;
    @(posedge clk); #1;
    instr = 16'hD7AA;
    chk("busy_decode", {31'h0, busy}, 32'h1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_no_early_done", {31'h0, done}, 32'h0);
    @(posedge clk); #1;
    chk("busy_done", {31'h0, done}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("busy_no_queue", {30'h0, busy, done}, 32'h0);
    end
    rd_chk("busy_r7", 3'd7, 16'h0005);

    // reset asserted while ADD R7,R0,R0 is in EXEC
    @(posedge clk); #1;
    instr = 16'hA0E0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_in_exec_busy", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy",   {31'h0, busy}, 32'h0);
    chk("abort_done",   {31'h0, done}, 32'h0);
    chk("abort_status", {29'h0, status}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", {30'h0, busy, done}, 32'h0);
    end
    rd_chk("abort_r7", 3'd7, 16'h0000);
    rd_chk("abort_r0", 3'd0, 16'h0000);

    @(posedge clk); #1;
    run_instr("recover", 16'hD007, 3, 1'b0);
    rd_chk("recover_r0", 3'd0, 16'h0007);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
